// File: rtl/alu_pkg.sv
// Shared ALU constants and state encoding for the sequential 64-bit adder.
package alu_pkg;

    localparam int unsigned SLICE_W    = 16;
    localparam int unsigned NUM_SLICES = 4;
    localparam int unsigned DATA_W     = SLICE_W * NUM_SLICES;
    localparam int unsigned IDX_W      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add_16.sv
// 16-bit ripple-carry adder slice shared by the sequential 64-bit adder.
module add_16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] s_o,
    output logic        c_o
);

    logic [16:0] carry;

    // Bit-serial carry ripple through the slice.
    always_comb begin
        carry    = '0;
        s_o      = '0;
        carry[0] = c_i;
        for (int i = 0; i < 16; i++) begin
            s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        c_o = carry[16];
    end

endmodule

// File: rtl/add64_seq_ctrl.sv
// Multi-cycle 64-bit add/subtract: one 16-bit slice reused over four cycles,
// LSB slice first, with a registered carry between slices.
// Optional zero-result flag enabled by defining ADD64_SEQ_CTRL_ZERO_FLAG_EN.
module add64_seq_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              c_out,
    output logic              overflow,
    output logic              busy
`ifdef ADD64_SEQ_CTRL_ZERO_FLAG_EN
    ,
    output logic              zero
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    state_e state_q, state_d;

    logic [NUM_SLICES-1:0][SLICE_W-1:0] a_q, a_d;
    logic [NUM_SLICES-1:0][SLICE_W-1:0] b_q, b_d;
    logic [NUM_SLICES-1:0][SLICE_W-1:0] sum_q, sum_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic                               carry_q, carry_d;
    logic                               c_out_q, c_out_d;
    logic                               ovf_q, ovf_d;
    logic                               in_ready_q, in_ready_d;
    logic                               out_valid_q, out_valid_d;
    logic                               busy_q, busy_d;
`ifdef ADD64_SEQ_CTRL_ZERO_FLAG_EN
    logic                               zero_q, zero_d;
    logic                               zero_acc_q, zero_acc_d;
`endif

    logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
    logic               slice_c;

    assign slice_a = a_q[idx_q];
    assign slice_b = b_q[idx_q];

    add_16 u_add_16 (
        .a_i (slice_a),
        .b_i (slice_b),
        .c_i (carry_q),
        .s_o (slice_s),
        .c_o (slice_c)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, operand latch, slice accumulation and status outputs.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        c_out_d    = c_out_q;
        ovf_d      = ovf_q;
`ifdef ADD64_SEQ_CTRL_ZERO_FLAG_EN
        zero_d     = zero_q;
        zero_acc_d = zero_acc_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = sub ? ~b : b;
                    carry_d    = sub;
                    idx_d      = '0;
`ifdef ADD64_SEQ_CTRL_ZERO_FLAG_EN
                    zero_acc_d = 1'b1;
`endif
                    state_d    = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = slice_s;
                carry_d      = slice_c;
                idx_d        = idx_q + IDX_W'(1);
`ifdef ADD64_SEQ_CTRL_ZERO_FLAG_EN
                zero_acc_d   = zero_acc_q & (slice_s == '0);
`endif
                if (idx_q == LAST_IDX) begin
                    c_out_d = slice_c;
                    ovf_d   = slice_a[SLICE_W-1] ^ slice_b[SLICE_W-1]
                            ^ slice_s[SLICE_W-1] ^ slice_c;
                    idx_d   = '0;
`ifdef ADD64_SEQ_CTRL_ZERO_FLAG_EN
                    zero_d  = zero_acc_q & (slice_s == '0);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ADD64_SEQ_CTRL_ZERO_FLAG_EN
            zero_q      <= 1'b0;
            zero_acc_q  <= 1'b0;
`endif
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef ADD64_SEQ_CTRL_ZERO_FLAG_EN
            zero_q      <= zero_d;
            zero_acc_q  <= zero_acc_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign overflow  = ovf_q;
`ifdef ADD64_SEQ_CTRL_ZERO_FLAG_EN
    assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_add64_seq_ctrl.sv
// Self-checking bench for add64_seq_ctrl: directed vectors, backpressure,
// mid-operation reset and randomized ops against a 65-bit reference model.
module tb_add64_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        c_out;
    logic        overflow;
    logic        busy;
`ifdef ADD64_SEQ_CTRL_ZERO_FLAG_EN
    logic        zero;
`endif

    int tests;
    int fails;
    int hs_cnt;
    int ops_done;

    add64_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow),
        .busy      (busy)
`ifdef ADD64_SEQ_CTRL_ZERO_FLAG_EN
        ,
        .zero      (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count result handshakes to detect lost or duplicated results.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) hs_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Reference: plain 65-bit two's-complement arithmetic.
    task automatic ref_model(input logic [63:0] ra, input logic [63:0] rb, input logic rsub,
                             output logic [63:0] rs, output logic rc, output logic rv);
        logic [63:0] bb;
        logic [64:0] r;
        bb = rsub ? ~rb : rb;
        r  = {1'b0, ra} + {1'b0, bb} + 65'(rsub);
        rs = r[63:0];
        rc = r[64];
        rv = (ra[63] == bb[63]) && (r[63] != ra[63]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, check latency and results, then drain after rdy_wait cycles.
    task automatic run_op(input string tag, input logic [63:0] oa, input logic [63:0] ob,
                          input logic osub, input logic [63:0] es, input logic ec,
                          input logic ev, input int rdy_wait);
        int edges;
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk({tag, " in_ready before issue"}, 64'(in_ready), 64'd1);
        a = oa; b = ob; sub = osub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = ~oa; b = ~ob; sub = ~osub;
        edges = 1;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        chk({tag, " latency edges"}, 64'(edges), 64'd5);
        for (int i = 0; i < rdy_wait; i++) tick();
        chk({tag, " sum"}, sum, es);
        chk({tag, " c_out"}, 64'(c_out), 64'(ec));
        chk({tag, " overflow"}, 64'(overflow), 64'(ev));
`ifdef ADD64_SEQ_CTRL_ZERO_FLAG_EN
        chk({tag, " zero"}, 64'(zero), 64'(es == 64'd0));
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        ops_done++;
        chk({tag, " in_ready after drain"}, 64'(in_ready), 64'd1);
        chk({tag, " out_valid after drain"}, 64'(out_valid), 64'd0);
        chk({tag, " sum held in IDLE"}, sum, es);
    endtask

    typedef struct {
        logic [63:0] va;
        logic [63:0] vb;
        logic        vsub;
        logic [63:0] es;
        logic        ec;
        logic        ev;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [63:0] held;
        logic [63:0] ra, rb, rs;
        logic        rsub, rc, rv;

        tests = 0; fails = 0; hs_cnt = 0; ops_done = 0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        rst = 1'b1;

        vecs[0] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0,                   1'b1, 1'b0};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{64'd5,                   64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{64'd10,                  64'd10, 1'b1, 64'h0,                  1'b1, 1'b0};

        #12;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset sum", sum, 64'd0);
        rst = 1'b0;
        tick();

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vsub,
                   vecs[i].es, vecs[i].ec, vecs[i].ev, 0);
        end

        // Backpressure: hold DONE for 10 cycles while a new op is offered.
        a = 64'h1111; b = 64'h2222; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) tick();
        held = sum;
        chk("bp result", held, 64'h3333);
        a = 64'hDEAD; b = 64'hBEEF; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp out_valid", 64'(out_valid), 64'd1);
            chk("bp sum stable", sum, held);
            chk("bp in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        ops_done++;
        chk("bp release in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("bp no stray accept", 64'(busy), 64'd0);

        // Reset during the second RUN cycle.
        a = 64'h1234; b = 64'h1; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("midrst sum", sum, 64'd0);
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst in_ready", 64'(in_ready), 64'd1);
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        run_op("post-rst", 64'd2, 64'd3, 1'b0, 64'd5, 1'b0, 1'b0, 0);

        // Randomized ops with idle and backpressure gaps.
        for (int i = 0; i < 20; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 5 == 1) rb = ra;
            if (i % 5 == 2) rb = ~ra;
            rsub = 1'($urandom_range(0, 1));
            ref_model(ra, rb, rsub, rs, rc, rv);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
            run_op($sformatf("rnd%0d", i), ra, rb, rsub, rs, rc, rv, int'($urandom_range(0, 3)));
        end

        chk("handshake count", 64'(hs_cnt), 64'(ops_done));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
